// File: rtl/button_debouncer.sv
// button_debouncer
//   Cleans up the raw board buttons and slide switches before they reach the
//   ALU operand/opcode loader. Each button is synchronized, debounced and
//   turned into a single-cycle press pulse. The switch bus is synchronized,
//   and a snapshot of it is taken on every press so the loader can use it as
//   load data in the same cycle as the pulse.
//
// Parameters
//   N_BTN     number of push buttons (bit 0 = load A, 1 = load B, 2 = load Op)
//   SW_W      switch bus width
//   DEBOUNCE  mclk cycles a synchronized input must differ from the stable
//             level before it is accepted (minimum 2)
//
// Ports
//   mclk       in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_raw    in   raw push-button pins, active high, asynchronous to mclk
//   switch     in   raw slide-switch pins, asynchronous to mclk
//   btn_level  out  debounced stable level per button
//   btn_pulse  out  one-cycle pulse on each debounced 0->1 transition
//   sw_sync    out  switch bus after a 2-FF synchronizer
//   sw_snap    out  sw_sync captured on the edge that raises any btn_pulse bit

module button_debouncer #(
  parameter int N_BTN    = 3,
  parameter int SW_W     = 8,
  parameter int DEBOUNCE = 500000
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [SW_W-1:0]  switch,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [SW_W-1:0]  sw_sync,
  output logic [SW_W-1:0]  sw_snap
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [N_BTN-1:0]            btn_s1;
  logic [N_BTN-1:0]            btn_s2;
  logic [SW_W-1:0]             sw_s1;
  logic [N_BTN-1:0][CNT_W-1:0] cnt;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_next;
  logic [N_BTN-1:0]            level_next;
  logic [N_BTN-1:0]            pulse_next;

  // Two-flop synchronizers for both the buttons and the switch bus.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      btn_s1  <= btn_raw;
      btn_s2  <= btn_s1;
      sw_s1   <= switch;
      sw_sync <= sw_s1;
    end
  end

  // Per-button debounce. The counter only runs while the synchronized input
  // disagrees with the accepted level; any agreement restarts it, so a bounce
  // shorter than DEBOUNCE cycles is rejected. The DEBOUNCE-1 compare bounds
  // the counter so it can never wrap.
  always_comb begin
    level_next = btn_level;
    cnt_next   = cnt;
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_s2[i] == btn_level[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        level_next[i] = btn_s2[i];
        cnt_next[i]   = '0;
      end else begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end
    end
    pulse_next = level_next & ~btn_level;
  end

  // Registered level, pulse and switch snapshot. The pulse is derived from
  // the next level so it rises together with btn_level; one snapshot serves
  // every button that pulses on the same edge.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      btn_level <= '0;
      btn_pulse <= '0;
      sw_snap   <= '0;
    end else begin
      cnt       <= cnt_next;
      btn_level <= level_next;
      btn_pulse <= pulse_next;
      if (|pulse_next) begin
        sw_snap <= sw_sync;
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer with DEBOUNCE = 4.
// Stimulus pushes expected press pulses (edge number, pulse bits, snapshot)
// into a queue; a monitor sampling on the falling edge pops and compares
// whenever btn_pulse is nonzero and flags pulses that never arrive.

module tb_button_debouncer;

  localparam int N_BTN    = 3;
  localparam int SW_W     = 8;
  localparam int DEBOUNCE = 4;

  typedef struct {
    int              at_edge;
    logic [N_BTN-1:0] pulse;
    logic [SW_W-1:0]  snap;
  } exp_t;

  logic             mclk;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [SW_W-1:0]  switch;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic [SW_W-1:0]  sw_sync;
  logic [SW_W-1:0]  sw_snap;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   k;

  button_debouncer #(
    .N_BTN   (N_BTN),
    .SW_W    (SW_W),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .mclk     (mclk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .switch   (switch),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .sw_sync  (sw_sync),
    .sw_snap  (sw_snap)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Count rising edges; at a falling edge edge_cnt is the number seen so far.
  always @(posedge mclk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic applyStimulus(input logic [N_BTN-1:0] b, input logic [SW_W-1:0] s);
    btn_raw = b;
    switch  = s;
  endtask

  task automatic expectPulse(input int at, input logic [N_BTN-1:0] p, input logic [SW_W-1:0] s);
    exp_t e;
    e.at_edge = at;
    e.pulse   = p;
    e.snap    = s;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // Scoreboard monitor: flags missed pulses, unexpected pulses, and wrong
  // pulse bits, snapshot or timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge mclk);
      while (exp_q.size() > 0 && exp_q[0].at_edge < edge_cnt) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("[TB] FAIL missed_pulse: got none expected %0b at edge %0d", e.pulse, e.at_edge);
      end
      if (btn_pulse !== '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse: got %0b expected none (edge %0d)", btn_pulse, edge_cnt);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulse_bits", 32'(btn_pulse), 32'(e.pulse));
          checkOutput("pulse_snap", 32'(sw_snap), 32'(e.snap));
          checkOutput("pulse_edge", 32'(edge_cnt), 32'(e.at_edge));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus('0, '0);
    tick(2);
    checkOutput("reset_level", 32'(btn_level), 32'h0);
    checkOutput("reset_pulse", 32'(btn_pulse), 32'h0);
    checkOutput("reset_sync", 32'(sw_sync), 32'h0);
    checkOutput("reset_snap", 32'(sw_snap), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Test 1: clean press of button 0, then release.
    k = edge_cnt;
    applyStimulus(3'b001, 8'h00);
    expectPulse(k + 6, 3'b001, 8'h00);
    tick(5);
    checkOutput("t1_level_before", 32'(btn_level), 32'h0);
    tick(1);
    checkOutput("t1_level_rise", 32'(btn_level), 32'h1);
    tick(3);
    checkOutput("t1_level_held", 32'(btn_level), 32'h1);
    checkOutput("t1_pulse_low", 32'(btn_pulse), 32'h0);
    applyStimulus(3'b000, 8'h00);
    tick(5);
    checkOutput("t1_release_before", 32'(btn_level), 32'h1);
    tick(1);
    checkOutput("t1_release_fall", 32'(btn_level), 32'h0);
    tick(3);

    // Test 2: 3-cycle glitch on button 1 is rejected.
    applyStimulus(3'b010, 8'h00);
    tick(3);
    applyStimulus(3'b000, 8'h00);
    tick(8);
    checkOutput("t2_glitch_level", 32'(btn_level), 32'h0);

    // Test 3: snapshot holds A5 while the switches change under a held button.
    applyStimulus(3'b000, 8'hA5);
    tick(3);
    checkOutput("t3_sync", 32'(sw_sync), 32'hA5);
    k = edge_cnt;
    applyStimulus(3'b100, 8'hA5);
    expectPulse(k + 6, 3'b100, 8'hA5);
    tick(7);
    applyStimulus(3'b100, 8'h3C);
    tick(4);
    checkOutput("t3_sync_new", 32'(sw_sync), 32'h3C);
    checkOutput("t3_snap_hold", 32'(sw_snap), 32'hA5);
    checkOutput("t3_level", 32'(btn_level), 32'h4);
    applyStimulus(3'b000, 8'h3C);
    tick(8);
    checkOutput("t3_release", 32'(btn_level), 32'h0);

    // Test 4: buttons 0 and 2 pressed on the same edge.
    k = edge_cnt;
    applyStimulus(3'b101, 8'h3C);
    expectPulse(k + 6, 3'b101, 8'h3C);
    tick(8);
    checkOutput("t4_snap", 32'(sw_snap), 32'h3C);
    checkOutput("t4_level", 32'(btn_level), 32'h5);
    applyStimulus(3'b000, 8'h3C);
    tick(8);

    // Test 5: reset after edge 3 of a held press; press restarts after reset.
    k = edge_cnt;
    applyStimulus(3'b001, 8'h3C);
    tick(4);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_level", 32'(btn_level), 32'h0);
    checkOutput("t5_rst_pulse", 32'(btn_pulse), 32'h0);
    checkOutput("t5_rst_sync", 32'(sw_sync), 32'h0);
    checkOutput("t5_rst_snap", 32'(sw_snap), 32'h0);
    @(negedge mclk);
    rst_n = 1'b1;
    k = edge_cnt;
    expectPulse(k + 6, 3'b001, 8'h3C);
    tick(5);
    checkOutput("t5_level_before", 32'(btn_level), 32'h0);
    tick(1);
    checkOutput("t5_level_rise", 32'(btn_level), 32'h1);
    applyStimulus(3'b000, 8'h3C);
    tick(8);

    // Test 6: bounce 1,0,1,0,1 then steady 1 on button 1.
    applyStimulus(3'b010, 8'h3C);
    tick(1);
    applyStimulus(3'b000, 8'h3C);
    tick(1);
    applyStimulus(3'b010, 8'h3C);
    tick(1);
    applyStimulus(3'b000, 8'h3C);
    tick(1);
    k = edge_cnt;
    applyStimulus(3'b010, 8'h3C);
    expectPulse(k + 6, 3'b010, 8'h3C);
    tick(5);
    checkOutput("t6_level_before", 32'(btn_level), 32'h0);
    tick(5);
    checkOutput("t6_level", 32'(btn_level), 32'h2);
    applyStimulus(3'b000, 8'h3C);
    tick(8);

    tick(2);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
